// File: rtl/alu_pkg.sv
// Shared types and constants for the 6-bit ALU datapath front end.
package alu_pkg;

  localparam int ALU_WIDTH        = 6;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    SHOW  = 2'd2
  } load_state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Operand bus from the loader to the combinational add/sub stage.
interface operand_loader_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             addSub;
  logic             opValid;

  modport master (output a, b, addSub, opValid);
  modport slave  (input  a, b, addSub, opValid);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, hold-time debouncer and rising-edge press pulse
// for one raw push button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic btn,
  output logic pulse
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic          armed;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments make sync1/sync2 a true two-stage chain;
  // blocking here would collapse it into a single flop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      armed   <= 1'b0;
      warm    <= 2'b00;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      warm    <= {warm[0], 1'b1};
      // A button held through reset must be seen released before it can press.
      if (warm[1] && !sync2 && !level)
        armed <= 1'b1;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_d & armed;

endmodule

// File: rtl/operand_loader.sv
// Loads operand A, then B and the add/sub select, from switches on debounced
// button presses. Optional OPLOAD_CANCEL_EN adds a cancel button that clears all.
module operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH           = ALU_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] sw,
  input  logic             opSel,
  input  logic             loadBtn,
`ifdef OPLOAD_CANCEL_EN
  input  logic             cancelBtn,
`endif
  output logic [1:0]       stage,
  operand_loader_if.master alu
);

  load_state_t state;
  logic        load_pulse;
  logic        cancel_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk    (clk),
    .resetN (resetN),
    .btn    (loadBtn),
    .pulse  (load_pulse)
  );

`ifdef OPLOAD_CANCEL_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel_db (
    .clk    (clk),
    .resetN (resetN),
    .btn    (cancelBtn),
    .pulse  (cancel_pulse)
  );
`else
  assign cancel_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= GET_A;
      alu.a       <= '0;
      alu.b       <= '0;
      alu.addSub  <= 1'b0;
      alu.opValid <= 1'b0;
    end else if (cancel_pulse) begin
      // Cancel outranks a load pulse landing in the same cycle.
      state       <= GET_A;
      alu.a       <= '0;
      alu.b       <= '0;
      alu.addSub  <= 1'b0;
      alu.opValid <= 1'b0;
    end else begin
      case (state)
        GET_A: if (load_pulse) begin
          alu.a <= sw;
          state <= GET_B;
        end
        GET_B: if (load_pulse) begin
          alu.b       <= sw;
          alu.addSub  <= opSel;
          alu.opValid <= 1'b1;
          state       <= SHOW;
        end
        SHOW: if (load_pulse) begin
          alu.opValid <= 1'b0;
          state       <= GET_A;
        end
        default: begin
          alu.opValid <= 1'b0;
          state       <= GET_A;
        end
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader with a 4-cycle debounce; cancel cases
// run only when OPLOAD_CANCEL_EN is defined.
module tb_operand_loader;
  import alu_pkg::*;

  localparam int W   = 6;
  localparam int D   = 4;
  localparam int LAT = 2 + D + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         add_sub;
    logic         valid;
    logic [1:0]   st;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetN;
  logic [W-1:0] sw;
  logic         opSel;
  logic         loadBtn;
`ifdef OPLOAD_CANCEL_EN
  logic         cancelBtn;
`endif
  logic [1:0]   stage;

  operand_loader_if #(.WIDTH(W)) alu_bus ();

  operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .sw        (sw),
    .opSel     (opSel),
    .loadBtn   (loadBtn),
`ifdef OPLOAD_CANCEL_EN
    .cancelBtn (cancelBtn),
`endif
    .stage     (stage),
    .alu       (alu_bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Reference model of the loaded registers.
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_add = 1'b0, m_v = 1'b0;
  logic [1:0]   m_st = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_load();
    case (m_st)
      2'd0: begin m_a = sw; m_st = 2'd1; end
      2'd1: begin m_b = sw; m_add = opSel; m_v = 1'b1; m_st = 2'd2; end
      default: begin m_v = 1'b0; m_st = 2'd0; end
    endcase
  endfunction

  function automatic void model_cancel();
    m_a = '0; m_b = '0; m_add = 1'b0; m_v = 1'b0; m_st = 2'd0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.a = m_a; e.b = m_b; e.add_sub = m_add; e.valid = m_v; e.st = m_st;
    sb.push_back(e);
  endfunction

  // Waits (bounded) for the stage to move, then checks the popped expectation.
  task automatic wait_update(input string tag, input int exp_lat);
    logic [1:0] prev;
    int         lat;
    exp_t       e;
    prev = stage;
    lat  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (stage !== prev) begin
        lat = i;
        break;
      end
    end
    check({tag, "_seen"}, 32'(lat != 0), 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    e = sb.pop_front();
    check({tag, "_a"},      alu_bus.a,       e.a);
    check({tag, "_b"},      alu_bus.b,       e.b);
    check({tag, "_addsub"}, alu_bus.addSub,  e.add_sub);
    check({tag, "_valid"},  alu_bus.opValid, e.valid);
    check({tag, "_stage"},  stage,           e.st);
  endtask

  task automatic release_all();
    loadBtn = 1'b0;
`ifdef OPLOAD_CANCEL_EN
    cancelBtn = 1'b0;
`endif
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic press(input string tag, input bit ld, input bit cn);
    if (cn) model_cancel();
    else    model_load();
    push_exp();
    @(posedge clk); #1;
    // NOTE: stimulus uses blocking assignments, placed 1 time unit after the edge.
    loadBtn = ld;
`ifdef OPLOAD_CANCEL_EN
    cancelBtn = cn;
`endif
    wait_update(tag, LAT);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_held"}, stage, m_st);
    release_all();
  endtask

  initial begin
    resetN  = 1'b0;
    loadBtn = 1'b1;
    sw      = '0;
    opSel   = 1'b0;
`ifdef OPLOAD_CANCEL_EN
    cancelBtn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_a",      alu_bus.a,       0);
    check("rst_b",      alu_bus.b,       0);
    check("rst_addsub", alu_bus.addSub,  0);
    check("rst_valid",  alu_bus.opValid, 0);
    check("rst_stage",  stage,           0);

    // Button held across reset release must not register as a press.
    @(negedge clk) resetN = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("held_rel_stage", stage,     0);
    check("held_rel_a",     alu_bus.a, 0);
    release_all();

    sw = 6'd5;
    press("load_a", 1'b1, 1'b0);
    sw = 6'd3; opSel = 1'b0;
    press("load_b", 1'b1, 1'b0);

    sw = 6'd63;
    repeat (10) @(posedge clk);
    #1;
    check("show_hold_a",     alu_bus.a,       5);
    check("show_hold_b",     alu_bus.b,       3);
    check("show_hold_valid", alu_bus.opValid, 1);
    press("show_exit", 1'b1, 1'b0);

    // Bouncing press: toggles every 2 cycles for 20 cycles, then settles high.
    sw = 6'd32;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      loadBtn = (i % 2 == 0);
      repeat (2) @(posedge clk);
      #1;
    end
    check("bounce_no_early", stage, 0);
    model_load();
    push_exp();
    loadBtn = 1'b1;
    wait_update("bounce", -1);
    repeat (8) @(posedge clk);
    #1;
    check("bounce_one_step", stage, 1);
    release_all();

    // Three-cycle glitch is below the debounce window.
    sw = 6'd1; opSel = 1'b1;
    loadBtn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    loadBtn = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("glitch_stage", stage,           1);
    check("glitch_b",     alu_bus.b,       3);
    check("glitch_valid", alu_bus.opValid, 0);

    press("load_b_sub", 1'b1, 1'b0);

`ifdef OPLOAD_CANCEL_EN
    press("to_get_a", 1'b1, 1'b0);
    sw = 6'd9;
    press("load_a9", 1'b1, 1'b0);
    press("cancel", 1'b0, 1'b1);
    sw = 6'd7;
    press("load_a7", 1'b1, 1'b0);
    sw = 6'd12;
    press("cancel_vs_load", 1'b1, 1'b1);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
